// File: rtl/led_scan_capture_pkg.sv
// led_scan_capture_pkg
//   Shared definitions for the seven-segment display bus.
//   - SEG_0..SEG_F : active-low abcdefg patterns for each hex digit (also used by the display path)
//   - SEG_A..SEG_G : bit positions of each segment inside seg[6:0]
//   - state_t      : reader FSM states
//   - decode_an    : one-hot-low anode decode (blanking/ghosting -> no selection)
package led_scan_capture_pkg;

   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F_BIT = 1;
   localparam int unsigned SEG_G = 0;

   localparam logic [6:0] SEG_0 = 7'b0000001;
   localparam logic [6:0] SEG_1 = 7'b1001111;
   localparam logic [6:0] SEG_2 = 7'b0010010;
   localparam logic [6:0] SEG_3 = 7'b0000110;
   localparam logic [6:0] SEG_4 = 7'b1001100;
   localparam logic [6:0] SEG_5 = 7'b0100100;
   localparam logic [6:0] SEG_6 = 7'b0100000;
   localparam logic [6:0] SEG_7 = 7'b0001111;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0000100;
   localparam logic [6:0] SEG_A_PAT = 7'b0001000;
   localparam logic [6:0] SEG_B_PAT = 7'b1100000;
   localparam logic [6:0] SEG_C_PAT = 7'b0110001;
   localparam logic [6:0] SEG_D_PAT = 7'b1000010;
   localparam logic [6:0] SEG_E_PAT = 7'b0110000;
   localparam logic [6:0] SEG_F_PAT = 7'b0111000;

   typedef enum logic [1:0] {
      S_WAIT,
      S_SETTLING,
      S_HELD
   } state_t;

   typedef struct packed {
      logic       sel;
      logic [1:0] idx;
   } digit_sel_t;

   // Exactly one anode low selects that digit; anything else is no selection.
   function automatic digit_sel_t decode_an(input logic [3:0] an);
      digit_sel_t r;
      r = '0;
      case (an)
         4'b1110: r = '{sel: 1'b1, idx: 2'd0};
         4'b1101: r = '{sel: 1'b1, idx: 2'd1};
         4'b1011: r = '{sel: 1'b1, idx: 2'd2};
         4'b0111: r = '{sel: 1'b1, idx: 2'd3};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/led_scan_capture_if.sv
// led_scan_capture_if
//   Display bus as seen by the loopback reader.
//   master : display path side (drives an/seg, observes the capture results)
//   slave  : reader side (samples an/seg, drives value/valid/err/timeout)
interface led_scan_capture_if;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic [15:0] value;
   logic        valid;
   logic        err;
   logic        timeout;

   modport master (output an, seg, input value, valid, err, timeout);
   modport slave  (input an, seg, output value, valid, err, timeout);
endinterface

// File: rtl/led_scan_capture_seg7_to_hex.sv
// seg7_to_hex
//   Combinational inverse of the LED decoder table.
//   seg    : active-low abcdefg pattern
//   nibble : decoded hex digit (0 when ok=0)
//   ok     : pattern is one of the 16 legal digits
module seg7_to_hex
   import led_scan_capture_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       ok
);
   always_comb begin
      nibble = '0;
      ok     = 1'b1;
      case (seg)
         SEG_0:     nibble = 4'h0;
         SEG_1:     nibble = 4'h1;
         SEG_2:     nibble = 4'h2;
         SEG_3:     nibble = 4'h3;
         SEG_4:     nibble = 4'h4;
         SEG_5:     nibble = 4'h5;
         SEG_6:     nibble = 4'h6;
         SEG_7:     nibble = 4'h7;
         SEG_8:     nibble = 4'h8;
         SEG_9:     nibble = 4'h9;
         SEG_A_PAT: nibble = 4'hA;
         SEG_B_PAT: nibble = 4'hB;
         SEG_C_PAT: nibble = 4'hC;
         SEG_D_PAT: nibble = 4'hD;
         SEG_E_PAT: nibble = 4'hE;
         SEG_F_PAT: nibble = 4'hF;
         default:   ok     = 1'b0;
      endcase
   end
endmodule

// File: rtl/led_scan_capture.sv
// led_scan_capture
//   Reads the multiplexed 4-digit seven-segment bus back into a 16-bit word.
//   clk   : rising-edge clock; an/seg are already synchronous to it
//   reset : asynchronous, active-high
//   bus   : slave modport -- an/seg in; value, valid, err, timeout out
//   SETTLE  : cycles an (an, seg) pair must dwell before it is sampled (2..255)
//   TIMEOUT : cycles from first captured digit before a partial frame is dropped
module led_scan_capture
   import led_scan_capture_pkg::*;
#(
   parameter int unsigned SETTLE  = 4,
   parameter int unsigned TIMEOUT = 65535
) (
   input logic               clk,
   input logic               reset,
   led_scan_capture_if.slave bus
);
   state_t      state_q, state_d;
   logic [3:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  mask_q, mask_d;
   logic [15:0] slots_q, slots_d;
   logic [15:0] value_q, value_d;
   logic [15:0] tmo_q, tmo_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        timeout_q, timeout_d;

   digit_sel_t  sel;
   logic        same;
   logic        sample;
   logic [3:0]  mask_cap;
   logic [3:0]  nibble;
   logic        hex_ok;

   seg7_to_hex u_dec (
      .seg    (bus.seg),
      .nibble (nibble),
      .ok     (hex_ok)
   );

   always_comb begin
      sel       = decode_an(bus.an);
      same      = (bus.an == an_q) && (bus.seg == seg_q);
      state_d   = state_q;
      an_d      = an_q;
      seg_d     = seg_q;
      cnt_d     = cnt_q;
      slots_d   = slots_q;
      value_d   = value_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      timeout_d = 1'b0;
      sample    = 1'b0;
      mask_cap  = mask_q;

      case (state_q)
         S_WAIT: begin
            if (sel.sel) begin
               an_d    = bus.an;
               seg_d   = bus.seg;
               cnt_d   = 8'd1;
               state_d = S_SETTLING;
            end
         end
         S_SETTLING: begin
            // an_q was a valid selection, so "unchanged" implies "still selected".
            if (!same) begin
               cnt_d   = '0;
               state_d = S_WAIT;
            end else if (cnt_q + 8'd1 == SETTLE[7:0]) begin
               cnt_d   = '0;
               sample  = 1'b1;
               state_d = S_HELD;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HELD: begin
            if (!same) state_d = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase

      if (sample) begin
         if (hex_ok) begin
            for (int unsigned i = 0; i < 4; i++) begin
               if (sel.idx == i[1:0]) begin
                  slots_d[i*4 +: 4] = nibble;
                  mask_cap[i]       = 1'b1;
               end
            end
         end else begin
            err_d    = 1'b1;
            mask_cap = '0;
         end
      end

      // Completion outranks timeout; a timeout also drops a concurrent partial capture.
      if (mask_cap == 4'b1111) begin
         value_d = slots_d;
         valid_d = 1'b1;
         mask_d  = '0;
      end else if ((mask_q != '0) && (tmo_q + 16'd1 == TIMEOUT[15:0])) begin
         timeout_d = 1'b1;
         mask_d    = '0;
      end else begin
         mask_d = mask_cap;
      end

      // Counts edges since the first capture of the current partial frame.
      if (mask_d == '0)       tmo_d = '0;
      else if (mask_q != '0)  tmo_d = tmo_q + 16'd1;
      else                    tmo_d = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_WAIT;
         an_q      <= '1;
         seg_q     <= '1;
         cnt_q     <= '0;
         mask_q    <= '0;
         slots_q   <= '0;
         value_q   <= '0;
         tmo_q     <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
         slots_q   <= slots_d;
         value_q   <= value_d;
         tmo_q     <= tmo_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.value   = value_q;
   assign bus.valid   = valid_q;
   assign bus.err     = err_q;
   assign bus.timeout = timeout_q;
endmodule

// File: doc/led_scan_capture.md
Name: led_scan_capture

Overview:
- Reader end of the on-board 4-digit seven-segment display bus.
- Monitors the time-multiplexed anode/segment lines driven by the display path and converts each stable segment pattern back to its hex nibble.
- Assembles one complete 4-digit frame and presents it as a 16-bit word with a valid pulse.
- Used for on-chip loopback checking of the display driver and LED decoder without external probes.

Parameters:
- SETTLE, 4: consecutive cycles an (an, seg) pair must be unchanged before it is sampled; legal range 2..255.
- TIMEOUT, 65535: maximum cycles from first captured digit to frame completion before the partial frame is discarded; 16-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- an  in  4  digit anodes, active-low; an[i]=0 selects digit i; digit 3 is the most significant nibble.
- seg  in  7  segments, active-low; seg[6]=a, seg[5]=b, …, seg[0]=g.
- value  out  16  last complete frame; value[4i+3:4i] = digit i.
- valid  out  1  one-cycle pulse when value is updated.
- err  out  1  one-cycle pulse when an undecodable pattern is sampled.
- timeout  out  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
Inputs and reset:
- an and seg are synchronous to clk; this block adds no synchronizers.
- Reset values: value=16'h0000, valid=0, err=0, timeout=0, state=WAIT, capture mask=4'b0000, all counters 0.
- Reset mid-frame discards all partial captures.

Decode table (seg, active-low, abcdefg → nibble):
- 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7.
- 0000000→8, 0000100→9, 0001000→A, 1100000→b, 0110001→C, 1000010→d, 0110000→E, 0111000→F.
- Any other pattern is invalid.

Digit select:
- A digit is selected only when an has exactly one bit low.
- an=4'b1111 (blanking) or more than one bit low (ghosting) counts as no selection.

FSM:
- WAIT: if a digit is selected, load the stability counter with 1, register (an, seg), go to SETTLING.
- SETTLING:
  - (an, seg) unchanged and still selected → counter+1.
  - Any change → return to WAIT on the same cycle; the counter does not carry over.
  - When counter reaches SETTLE, sample on that edge and go to HELD.
- HELD: no further samples while (an, seg) is unchanged. Any change → WAIT, so a new dwell is evaluated from the next cycle.

Sample action:
- Valid pattern: store nibble into digit slot i and set mask[i]. A re-captured digit overwrites its slot.
- Invalid pattern: err=1 for one cycle, mask cleared, slots unchanged.
- Mask becomes 4'b1111: value updated and valid=1 on the cycle after the sample edge (1-cycle latency); mask cleared on the same cycle.

Timeout:
- The timeout counter runs while mask≠0 and resets whenever mask returns to 0.
- On reaching TIMEOUT: timeout=1 for one cycle and mask cleared.

Simultaneous events:
- Frame completion and timeout on the same cycle: completion wins, timeout is suppressed.
- err and valid are never asserted together.
- value holds between valid pulses.

Decomposition:
- Shared include file seg7_defs.vh holds:
  - localparams SEG_0..SEG_F (the 16 active-low patterns above, also consumed by the display path);
  - bit-index constants SEG_A..SEG_G;
  - FSM state encodings S_WAIT, S_SETTLING, S_HELD.
- Sub-module seg7_to_hex: purely combinational; inputs seg[6:0]; outputs nibble[3:0] and ok. It is the exact inverse of the LED decoder's table and is instantiated once.

Test Plan:
- Sweep digits 0..3 with an=1110/1101/1011/0111, seg=SEG_4/SEG_3/SEG_2/SEG_1, each held 8 cycles (SETTLE=4) → exactly one valid pulse, 1 cycle after the 4th sample; value=16'h1234, err=0.
- All 16 patterns fed on digit 0, other digits fixed at SEG_0, one frame per pattern → value[3:0] steps 0..F; seg=7'b1111111 on digit 2 → err pulse, no valid, mask cleared.
- Digit 1 dwell of SETTLE-1 cycles, then a one-cycle seg glitch mid-dwell → no capture; a following clean dwell of SETTLE cycles → captured once.
- an=4'b1100 for 20 cycles, and an=4'b1111 gaps between digits → no samples from the ghosted dwell; the blank gaps do not break a frame, which completes with the correct value.
- Capture digits 0 and 1 only, then idle with TIMEOUT=100 → timeout pulse exactly 100 cycles after the first capture; the next full sweep yields a valid frame.
- Assert reset for 1 cycle after 3 digits are captured → outputs return to reset values; a subsequent digit-3 capture alone produces no valid pulse.
